regfile_sequencer: RTL and testbench
====================================

Name: regfile_sequencer

Overview:
- Micro-sequencer that owns all ports of the team's 8x8 two-read/one-write register file and executes one 20-bit register-transfer instruction at a time.
- Instructions arrive over a valid/ready handshake. The sequencer reads operands, computes an 8-bit result, writes it back, then signals completion.
- Sits between the instruction source (testbench or future fetch unit) and the register file. Nothing else drives the register-file ports.

Parameters:
- DW, 8, data width of the register file and ALU
- AW, 3, register address width (2^AW registers)
- CW, 16, width of the retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer can accept an instruction
- instr  in  20  op[19:17], rd[16:14], rs1[13:11], rs2[10:8], imm[7:0]
- rf_read_p_1  out  AW  register file read address 1
- rf_read_p_2  out  AW  register file read address 2
- rf_r1  out  1  register file read enable 1
- rf_r2  out  1  register file read enable 2
- rf_write_p  out  AW  register file write address
- rf_write_data  out  DW  register file write data
- rf_w  out  1  register file write enable
- rf_read_data1  in  DW  register file read data 1 (registered, 1-cycle latency)
- rf_read_data2  in  DW  register file read data 2
- done  out  1  one-cycle pulse, coincident with the write-back cycle
- result  out  DW  last written-back value
- zero  out  1  result == 0
- carry  out  1  carry of ADD / borrow of SUB; cleared by other ops
- retired  out  CW  count of completed non-NOP instructions, wraps

Behaviour:
- Reset (async) forces IDLE. All outputs are 0, except instr_ready, which is 1 in IDLE.
- Reset mid-operation abandons the instruction: no write-back and no done.
- Opcodes:
  - 000 NOP
  - 001 LDI: rd <= imm
  - 010 ADD: rd <= rs1+rs2
  - 011 SUB: rd <= rs1-rs2
  - 100 AND
  - 101 OR
  - 110 XOR
  - 111 MOV: rd <= rs1
- ALU width rules: result truncated to DW. carry = bit DW of the (DW+1)-bit sum for ADD. For SUB, carry = 1 when rs1 < rs2 (unsigned).
- FSM states: IDLE, READ, EXEC, WRITE.
- IDLE:
  - instr_ready = 1.
  - On instr_valid & instr_ready, latch instr.
  - Next state: NOP -> stay IDLE (no done, no count). LDI -> WRITE. Other ops -> READ.
- READ (1 cycle):
  - rf_r1 = 1 with rf_read_p_1 = rs1.
  - rf_r2 = 1 with rf_read_p_2 = rs2 for ADD/SUB/AND/OR/XOR; rf_r2 = 0 for MOV.
  - rf_w = 0.
  - -> EXEC.
- EXEC (1 cycle): rf_read_data1/2 are valid. Compute and register result, zero and carry. -> WRITE.
- WRITE (1 cycle):
  - rf_w = 1, rf_write_p = rd, rf_write_data = result (imm for LDI).
  - done = 1. retired increments. -> IDLE.
- instr_ready is 0 in READ, EXEC and WRITE. instr_valid is ignored there.
- Read and write are never asserted in the same cycle. This avoids the register file's read suppression when a read address equals rf_write_p.
- rf_r1, rf_r2 and rf_w are registered outputs, deasserted in every state other than the one that owns them.
- Addresses and data may hold stale values when their enables are low.
- Latency from the accept edge to done:
  - LDI: done in the next cycle.
  - ALU/MOV: done 3 cycles after accept.
- Back-to-back issue: the next instruction is accepted in the cycle after WRITE.
- rd == rs1 or rd == rs2 is legal. Operands are read before write-back.
- retired wraps from 2^CW-1 to 0.

Test Plan:
- Reset asserted mid-READ of ADD -> all outputs 0 next cycle, instr_ready=1, retired unchanged, no rf_w pulse.
- LDI r1=0x05, LDI r2=0xFB, ADD r3=r1+r2 -> write-back r3=0x00, zero=1, carry=1, done pulses 3 times, retired=3. ADD done occurs 3 cycles after its accept.
- SUB r4=r1-r2 (0x05-0xFB) -> r4=0x0A, carry=1, zero=0. Then XOR r5=r2^r2 -> 0x00, zero=1, carry=0.
- MOV r1=r3, with r3=0x00 -> rf_r2 stays 0 throughout; r1=0x00. Check that rf_r1 and rf_w are never high in the same cycle for the whole run.
- NOP offered with instr_valid held high -> accepted in one cycle, no done, no rf_w, retired unchanged. A following LDI r7=0xA5 is accepted on the next cycle and writes 0xA5.
- instr_valid held high for 4 ALU instructions back-to-back -> accepts spaced exactly 4 cycles apart; instr is not sampled while instr_ready=0.

Source files
------------

// File: rtl/regfile_sequencer_if.sv
// rtl/regfile_sequencer_if.sv - instruction handshake and register-file bus between sequencer and its environment
//
// Purpose: groups the instruction valid/ready channel and every register-file
// port into one bundle.
//   master : sequencer side. Drives instr_ready and all rf_* controls.
//            Receives instr_valid, instr and the registered read data.
//   slave  : environment side (instruction source plus register file).
// Signals:
//   instr_valid / instr_ready / instr[19:0]  instruction handshake
//   rf_read_p_1, rf_r1, rf_read_data1         read port 1
//   rf_read_p_2, rf_r2, rf_read_data2         read port 2
//   rf_write_p, rf_write_data, rf_w           write port
interface regfile_sequencer_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic          instr_valid;
  logic          instr_ready;
  logic [19:0]   instr;
  logic [AW-1:0] rf_read_p_1;
  logic [AW-1:0] rf_read_p_2;
  logic          rf_r1;
  logic          rf_r2;
  logic [AW-1:0] rf_write_p;
  logic [DW-1:0] rf_write_data;
  logic          rf_w;
  logic [DW-1:0] rf_read_data1;
  logic [DW-1:0] rf_read_data2;

  modport master (
    input  instr_valid, instr, rf_read_data1, rf_read_data2,
    output instr_ready, rf_read_p_1, rf_read_p_2, rf_r1, rf_r2,
           rf_write_p, rf_write_data, rf_w
  );

  modport slave (
    output instr_valid, instr, rf_read_data1, rf_read_data2,
    input  instr_ready, rf_read_p_1, rf_read_p_2, rf_r1, rf_r2,
           rf_write_p, rf_write_data, rf_w
  );
endinterface

// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - micro-sequencer executing one register-transfer instruction at a time on an 8x8 2R1W register file
//
// Purpose: accepts a 20-bit instruction, reads its operands from the register
// file, computes an ALU result and writes it back, pulsing done on write-back.
// Instruction format: op[19:17] rd[16:14] rs1[13:11] rs2[10:8] imm[7:0]
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-high reset
//   bus      regfile_sequencer_if.master: instruction handshake + register file
//   done     one-cycle pulse coincident with the write-back cycle
//   result   last written-back value
//   zero     result == 0
//   carry    ADD carry / SUB borrow, cleared by every other op
//   retired  count of completed non-NOP instructions (wraps)
module regfile_sequencer #(
  parameter int DW = 8,
  parameter int AW = 3,
  parameter int CW = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_sequencer_if.master   bus,
  output logic                  done,
  output logic [DW-1:0]         result,
  output logic                  zero,
  output logic                  carry,
  output logic [CW-1:0]         retired
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_MOV = 3'b111;

  logic [1:0]  state;
  logic [19:0] ir;

  // Fields of the instruction being offered (used on the accept edge)
  logic [2:0]    in_op;
  logic [AW-1:0] in_rd;
  logic [AW-1:0] in_rs1;
  logic [AW-1:0] in_rs2;
  logic [DW-1:0] in_imm;

  // Fields of the latched instruction (used in EXEC)
  logic [2:0]    ir_op;
  logic [AW-1:0] ir_rd;

  assign in_op  = bus.instr[19:17];
  assign in_rd  = bus.instr[14+AW-1:14];
  assign in_rs1 = bus.instr[11+AW-1:11];
  assign in_rs2 = bus.instr[8+AW-1:8];
  assign in_imm = bus.instr[DW-1:0];

  assign ir_op  = ir[19:17];
  assign ir_rd  = ir[14+AW-1:14];

  // Ready only while idle; instr_valid is ignored in every other state
  assign bus.instr_ready = (state == S_IDLE);

  // ALU on the register-file read data, valid during EXEC
  logic [DW:0]   sum;
  logic [DW-1:0] alu_res;
  logic          alu_carry;

  always_comb begin
    sum       = {1'b0, bus.rf_read_data1} + {1'b0, bus.rf_read_data2};
    alu_res   = '0;
    alu_carry = 1'b0;
    case (ir_op)
      OP_ADD: begin
        alu_res   = sum[DW-1:0];
        alu_carry = sum[DW];
      end
      OP_SUB: begin
        alu_res   = bus.rf_read_data1 - bus.rf_read_data2;
        // Borrow: unsigned rs1 < rs2
        alu_carry = (bus.rf_read_data1 < bus.rf_read_data2);
      end
      OP_AND:  alu_res = bus.rf_read_data1 & bus.rf_read_data2;
      OP_OR:   alu_res = bus.rf_read_data1 | bus.rf_read_data2;
      OP_XOR:  alu_res = bus.rf_read_data1 ^ bus.rf_read_data2;
      OP_MOV:  alu_res = bus.rf_read_data1;
      default: alu_res = '0;
    endcase
  end

  // All register-file controls are registered: each enable is set on the
  // edge entering the state that owns it and cleared on the edge leaving it,
  // so a read enable and the write enable can never overlap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= S_IDLE;
      ir                <= '0;
      bus.rf_read_p_1   <= '0;
      bus.rf_read_p_2   <= '0;
      bus.rf_r1         <= 1'b0;
      bus.rf_r2         <= 1'b0;
      bus.rf_write_p    <= '0;
      bus.rf_write_data <= '0;
      bus.rf_w          <= 1'b0;
      done              <= 1'b0;
      result            <= '0;
      zero              <= 1'b0;
      carry             <= 1'b0;
      retired           <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.instr_valid) begin
            ir <= bus.instr;
            case (in_op)
              OP_NOP: state <= S_IDLE;
              OP_LDI: begin
                // No operands: go straight to write-back with the immediate
                state             <= S_WRITE;
                bus.rf_w          <= 1'b1;
                bus.rf_write_p    <= in_rd;
                bus.rf_write_data <= in_imm;
                done              <= 1'b1;
                result            <= in_imm;
                zero              <= (in_imm == '0);
                carry             <= 1'b0;
              end
              default: begin
                state           <= S_READ;
                bus.rf_r1       <= 1'b1;
                bus.rf_read_p_1 <= in_rs1;
                // MOV only needs the first operand
                bus.rf_r2       <= (in_op != OP_MOV);
                bus.rf_read_p_2 <= in_rs2;
              end
            endcase
          end
        end

        S_READ: begin
          // Read data returns one cycle later, in EXEC
          state     <= S_EXEC;
          bus.rf_r1 <= 1'b0;
          bus.rf_r2 <= 1'b0;
        end

        S_EXEC: begin
          state             <= S_WRITE;
          result            <= alu_res;
          zero              <= (alu_res == '0);
          carry             <= alu_carry;
          bus.rf_w          <= 1'b1;
          bus.rf_write_p    <= ir_rd;
          bus.rf_write_data <= alu_res;
          done              <= 1'b1;
        end

        S_WRITE: begin
          state    <= S_IDLE;
          bus.rf_w <= 1'b0;
          done     <= 1'b0;
          retired  <= retired + {{(CW-1){1'b0}}, 1'b1};
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb/tb_regfile_sequencer.sv - self-checking bench for regfile_sequencer with register-file model and reference model
module tb_regfile_sequencer;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          done;
  logic [DW-1:0] result;
  logic          zero;
  logic          carry;
  logic [CW-1:0] retired;

  always #5 clk = ~clk;

  regfile_sequencer_if #(.DW(DW), .AW(AW)) bus ();

  regfile_sequencer #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .done    (done),
    .result  (result),
    .zero    (zero),
    .carry   (carry),
    .retired (retired)
  );

  // Register file: 8x8, registered reads, read suppressed on address clash with write
  logic [DW-1:0] mem [8];
  logic [DW-1:0] rd1_q;
  logic [DW-1:0] rd2_q;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else begin
      if (bus.rf_w) mem[bus.rf_write_p] <= bus.rf_write_data;
      if (bus.rf_r1 && !(bus.rf_w && bus.rf_read_p_1 == bus.rf_write_p)) rd1_q <= mem[bus.rf_read_p_1];
      if (bus.rf_r2 && !(bus.rf_w && bus.rf_read_p_2 == bus.rf_write_p)) rd2_q <= mem[bus.rf_read_p_2];
    end
  end
  assign bus.rf_read_data1 = rd1_q;
  assign bus.rf_read_data2 = rd2_q;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Whole-run monitors
  int  overlaps = 0;
  int  mov_r2   = 0;
  bit  mov_watch = 0;
  always @(negedge clk) begin
    if (bus.rf_w && (bus.rf_r1 || bus.rf_r2)) overlaps++;
    if (mov_watch && bus.rf_r2) mov_r2++;
  end

  // Reference model: architectural register contents and retire count
  int     ref_rf [8];
  int     exp_retired = 0;
  longint last_acc = 0;

  function automatic logic [19:0] mk(input int op, input int rd, input int rs1, input int rs2, input int imm);
    logic [19:0] v;
    v = {op[2:0], rd[2:0], rs1[2:0], rs2[2:0], imm[7:0]};
    return v;
  endfunction

  task automatic run_instr(input logic [19:0] ins, input bit hold);
    int op, rd, a, b, res, c, n, lat;
    op  = int'(ins[19:17]);
    rd  = int'(ins[16:14]);
    a   = ref_rf[int'(ins[13:11])];
    b   = ref_rf[int'(ins[10:8])];
    c   = 0;
    case (op)
      1: res = int'(ins[7:0]);
      2: begin res = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
      3: begin res = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      4: res = a & b;
      5: res = a | b;
      6: res = a ^ b;
      7: res = a;
      default: res = 0;
    endcase

    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    n = 0;
    while (!bus.instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      check("accept_timeout", 1, 0);
      return;
    end
    last_acc = longint'($time);
    @(negedge clk);
    if (hold) bus.instr = 20'($urandom);
    else      bus.instr_valid = 1'b0;

    if (op == 0) begin
      check("nop_done", 32'(done), 0);
      check("nop_rf_w", 32'(bus.rf_w), 0);
      check("nop_ready", 32'(bus.instr_ready), 1);
      check("nop_retired", 32'(retired), 32'(exp_retired));
      return;
    end

    lat = 1;
    while (!done && lat < 10) begin
      @(negedge clk);
      if (hold) bus.instr = 20'($urandom);
      lat++;
    end
    check("latency", 32'(lat), (op == 1) ? 1 : 3);
    check("wb_rf_w", 32'(bus.rf_w), 1);
    check("wb_addr", 32'(bus.rf_write_p), 32'(rd));
    check("wb_data", 32'(bus.rf_write_data), 32'(res));
    check("result", 32'(result), 32'(res));
    check("zero", 32'(zero), (res == 0) ? 1 : 0);
    check("carry", 32'(carry), 32'(c));
    check("busy_ready", 32'(bus.instr_ready), 0);
    ref_rf[rd] = res;
    exp_retired = (exp_retired + 1) % 65536;
    @(negedge clk);
    check("retired", 32'(retired), 32'(exp_retired));
    check("idle_ready", 32'(bus.instr_ready), 1);
    check("done_pulse", 32'(done), 0);
  endtask

  initial begin
    longint prev;
    int     bad;
    bit     hold;
    logic [19:0] ins;

    for (int i = 0; i < 8; i++) ref_rf[i] = 0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    reset = 1'b1;
    #1;
    check("rst_ready", 32'(bus.instr_ready), 1);
    check("rst_outs", {29'd0, done, zero, carry}, 0);
    check("rst_rf", {29'd0, bus.rf_r1, bus.rf_r2, bus.rf_w}, 0);
    check("rst_result", 32'(result), 0);
    check("rst_retired", 32'(retired), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset in the middle of READ abandons the ADD
    bus.instr_valid = 1'b1;
    bus.instr       = mk(2, 3, 1, 2, 0);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    check("mid_read_r1", 32'(bus.rf_r1), 1);
    reset = 1'b1;
    #1;
    check("mid_rst_rf", {29'd0, bus.rf_r1, bus.rf_r2, bus.rf_w}, 0);
    check("mid_rst_ready", 32'(bus.instr_ready), 1);
    check("mid_rst_done", 32'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.rf_w || done) bad++;
    end
    check("mid_rst_no_wb", 32'(bad), 0);
    check("mid_rst_retired", 32'(retired), 0);

    // Directed sequence
    run_instr(mk(1, 1, 0, 0, 8'h05), 0);
    run_instr(mk(1, 2, 0, 0, 8'hFB), 0);
    run_instr(mk(2, 3, 1, 2, 0), 0);
    check("add_r3", 32'(mem[3]), 0);
    check("retired3", 32'(retired), 3);
    run_instr(mk(3, 4, 1, 2, 0), 0);
    check("sub_r4", 32'(mem[4]), 32'h0A);
    run_instr(mk(6, 5, 2, 2, 0), 0);
    mov_watch = 1;
    run_instr(mk(7, 1, 3, 6, 0), 0);
    mov_watch = 0;
    check("mov_r2_low", 32'(mov_r2), 0);
    check("mov_r1", 32'(mem[1]), 0);

    // NOP with valid held, followed immediately by LDI
    run_instr(mk(0, 0, 0, 0, 0), 1);
    prev = last_acc;
    run_instr(mk(1, 7, 0, 0, 8'hA5), 1);
    bus.instr_valid = 1'b0;
    check("nop_ldi_gap", 32'((last_acc - prev) / 10), 1);
    check("ldi_r7", 32'(mem[7]), 32'hA5);
    @(negedge clk);

    // Back-to-back ALU instructions with valid held, garbage while busy
    run_instr(mk(2, 6, 7, 2, 0), 1);
    for (int k = 0; k < 3; k++) begin
      prev = last_acc;
      run_instr(mk(2 + k, k, 6, 7, 0), 1);
      check("b2b_gap", 32'((last_acc - prev) / 10), 4);
    end
    bus.instr_valid = 1'b0;
    @(negedge clk);

    // Randomized instructions against the reference model
    for (int k = 0; k < 60; k++) begin
      ins  = 20'($urandom);
      hold = 1'($urandom_range(0, 1));
      run_instr(ins, hold);
      if (!hold || $urandom_range(0, 3) == 0) begin
        bus.instr_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    bus.instr_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) check("final_rf", 32'(mem[i]), 32'(ref_rf[i]));
    check("final_retired", 32'(retired), 32'(exp_retired));
    check("rd_wr_overlap", 32'(overlaps), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
